mem_ctrl: RTL

Parametrised request/acknowledge controller wrapping a private synchronous memory array. It generalises the fixed 8-bit, 8-word read/write FSM to configurable data width and depth, and uses an explicit REQ/ACK handshake with a BUSY flag. It also adds a bulk-clear mode that zeroes the whole array. It sits between datapath logic and its local storage: all array accesses go through this controller.

---
 rtl/mem_ctrl_pkg.sv | 16 +
 rtl/mem_array.sv | 24 ++
 rtl/mem_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the request/acknowledge memory controller:
// default geometry and the FSM state encoding.
package mem_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Private storage behind mem_ctrl: one synchronous write port and one
// registered read port, no reset on contents.
module mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_ctrl.sv
// REQ/ACK controller around mem_array: single-word read/write plus a
// bulk clear that walks every address writing zero.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic              CLR,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              ACK,
    output logic              BUSY
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              we_q;
    logic [ADDR_W-1:0] cnt;
    logic              rd_done;
    logic [DATA_W-1:0] dout_q;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_waddr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            cnt     <= '0;
            rd_done <= 1'b0;
            dout_q  <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && REQ) begin
                addr_q <= ADDR;
                din_q  <= DIN;
                we_q   <= WE;
            end
            // The counter's increment from all-ones back to zero is never observed.
            if (state == ST_IDLE) begin
                cnt <= '0;
            end else if (state == ST_CLEAR) begin
                cnt <= cnt + 1'b1;
            end
            rd_done <= (state == ST_READ);
            if (rd_done) begin
                dout_q <= arr_rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (REQ) begin
                    if (CLR) begin
                        state_next = ST_CLEAR;
                    end else if (WE) begin
                        state_next = ST_WRITE;
                    end else begin
                        state_next = ST_READ;
                    end
                end
            end
            ST_WRITE: state_next = ST_DONE;
            ST_READ:  state_next = ST_DONE;
            ST_CLEAR: begin
                if (cnt == '1) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Reset must suppress the array write scheduled for the same edge.
    assign arr_we    = ((state == ST_WRITE && we_q) || state == ST_CLEAR) && !RST;
    assign arr_waddr = (state == ST_CLEAR) ? cnt : addr_q;
    assign arr_wdata = (state == ST_CLEAR) ? '0 : din_q;

    // Fresh read data is forwarded in the ACK cycle, then held in dout_q.
    assign DOUT = rd_done ? arr_rdata : dout_q;
    assign ACK  = (state == ST_DONE);
    assign BUSY = (state != ST_IDLE);

    mem_array #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem_array (
        .CLK  (CLK),
        .we   (arr_we),
        .waddr(arr_waddr),
        .wdata(arr_wdata),
        .raddr(addr_q),
        .rdata(arr_rdata)
    );

endmodule
